// File: rtl/histogram_fill_drain_if.sv
// Hit input stream and drain output stream of the r-bin histogram.
// The histogram itself uses the slave view; the producer/consumer side uses master.
interface histogram_fill_drain_if #(
  parameter int unsigned RBIN_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic [RBIN_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [RBIN_WIDTH-2:0] out_bin;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_bin, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_bin, out_count, out_valid
  );
endinterface

// File: rtl/histogram_fill_drain.sv
// Per-event r-bin histogram: saturating fill with running max, thresholded in-order drain,
// then a one-cycle self-clear before the next event.
module histogram_fill_drain #(
  parameter int unsigned RBINS      = 128,
  parameter int unsigned RBIN_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  histogram_fill_drain_if.slave bus,
  input  logic [CNT_WIDTH-1:0]  thr_i,
  output logic [RBIN_WIDTH-2:0] max_bin,
  output logic [CNT_WIDTH-1:0]  max_count,
  output logic                  max_vld,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  ovf_o
);
  localparam int unsigned IW = RBIN_WIDTH - 1;

  typedef enum logic [1:0] {StFill, StDrain, StClear} state_e;
  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] bin_q [RBINS];

  logic [IW-1:0]        max_bin_q, max_bin_d, ptr_q, ptr_d, out_bin_q, out_bin_d;
  logic [CNT_WIDTH-1:0] max_cnt_q, max_cnt_d, thr_q, thr_d, out_cnt_q, out_cnt_d;
  logic                 max_vld_q, max_vld_d, ovf_q, ovf_d;
  logic                 scan_end_q, scan_end_d, out_valid_q, out_valid_d;

  logic                 in_fire, hit_ok, hit_sat, hit_inc;
  logic [IW-1:0]        idx;
  logic [CNT_WIDTH-1:0] hit_cur, hit_cnt;
  logic                 soft_rst;

  assign soft_rst = !rst_n || clear_i;

  assign idx     = bus.in_data[IW-1:0];
  assign in_fire = bus.in_valid && bus.in_ready;
  assign hit_ok  = in_fire && !bus.in_data[RBIN_WIDTH-1] && (32'(idx) < RBINS);
  assign hit_cur = bin_q[idx];
  assign hit_sat = (hit_cur == '1);
  assign hit_inc = hit_ok && !hit_sat;
  assign hit_cnt = hit_cur + CNT_WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (soft_rst) state_q <= StFill;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (in_fire && bus.in_last) state_d = StDrain;
      StDrain: if (done_o) state_d = StClear;
      StClear: state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = (state_q == StFill);
    busy_o       = (state_q != StFill);
    done_o       = (state_q == StDrain) && scan_end_q && !out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (soft_rst || state_q == StClear) begin
      for (int unsigned i = 0; i < RBINS; i++) bin_q[i] <= '0;
    end else if (hit_inc) begin
      bin_q[idx] <= hit_cnt;
    end
  end

  always_comb begin
    max_bin_d   = max_bin_q;
    max_cnt_d   = max_cnt_q;
    max_vld_d   = 1'b0;
    ovf_d       = ovf_q;
    thr_d       = thr_q;
    ptr_d       = ptr_q;
    scan_end_d  = scan_end_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_cnt_d   = out_cnt_q;
    unique case (state_q)
      StFill: begin
        if (hit_ok && hit_sat) begin
          ovf_d = 1'b1;
        end else if (hit_inc && hit_cnt > max_cnt_q) begin
          max_bin_d = idx;
          max_cnt_d = hit_cnt;
          max_vld_d = 1'b1;
        end
        if (in_fire && bus.in_last) thr_d = thr_i;
      end
      StDrain: begin
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        // Scan only when the output register is free or being consumed this cycle.
        if (!scan_end_q && (!out_valid_q || bus.out_ready)) begin
          if (bin_q[ptr_q] >= thr_q) begin
            out_valid_d = 1'b1;
            out_bin_d   = ptr_q;
            out_cnt_d   = bin_q[ptr_q];
          end
          if (32'(ptr_q) == RBINS - 1) scan_end_d = 1'b1;
          else                         ptr_d      = ptr_q + IW'(1);
        end
      end
      StClear: begin
        max_bin_d   = '0;
        max_cnt_d   = '0;
        ovf_d       = 1'b0;
        ptr_d       = '0;
        scan_end_d  = 1'b0;
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      max_bin_q   <= '0;
      max_cnt_q   <= '0;
      max_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
      thr_q       <= '0;
      ptr_q       <= '0;
      scan_end_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      max_bin_q   <= max_bin_d;
      max_cnt_q   <= max_cnt_d;
      max_vld_q   <= max_vld_d;
      ovf_q       <= ovf_d;
      thr_q       <= thr_d;
      ptr_q       <= ptr_d;
      scan_end_q  <= scan_end_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign max_bin       = max_bin_q;
  assign max_count     = max_cnt_q;
  assign max_vld       = max_vld_q;
  assign ovf_o         = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_count = out_cnt_q;
endmodule

// File: tb/tb_histogram_fill_drain.sv
// Randomised and directed checks of histogram_fill_drain against a bin-array reference model.
module tb_histogram_fill_drain;
  localparam int unsigned RBINS = 128;
  localparam int unsigned RW    = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear_i;
  logic [CW-1:0] thr_i;
  logic [RW-2:0] max_bin;
  logic [CW-1:0] max_count;
  logic          max_vld, done_o, busy_o, ovf_o;

  histogram_fill_drain_if #(.RBIN_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  histogram_fill_drain #(.RBINS(RBINS), .RBIN_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear_i),
    .bus      (bus),
    .thr_i    (thr_i),
    .max_bin  (max_bin),
    .max_count(max_count),
    .max_vld  (max_vld),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-event bin counts plus running max and overflow flag.
  int unsigned m_bins [RBINS];
  int unsigned m_max_cnt, m_max_bin;
  bit          m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < RBINS; i++) m_bins[i] = 0;
    m_max_cnt = 0;
    m_max_bin = 0;
    m_ovf     = 0;
  endfunction

  function automatic bit m_hit(input int unsigned data);
    int unsigned idx;
    idx = data % (1 << (RW - 1));
    if (((data >> (RW - 1)) & 1) == 1 || idx >= RBINS) return 0;
    if (m_bins[idx] == SAT) begin
      m_ovf = 1;
      return 0;
    end
    m_bins[idx]++;
    if (m_bins[idx] > m_max_cnt) begin
      m_max_cnt = m_bins[idx];
      m_max_bin = idx;
      return 1;
    end
    return 0;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    check_eq("idle_max_vld", max_vld, 0);
  endtask

  task automatic send_hit(input int unsigned data, input bit last, input int unsigned thr,
                          output bit obs_vld);
    bit evld;
    bus.in_valid = 1'b1;
    bus.in_data  = RW'(data);
    bus.in_last  = last;
    thr_i        = CW'(thr);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    evld = m_hit(data);
    obs_vld = max_vld;
    check_eq("max_vld", max_vld, evld);
    check_eq("max_count", max_count, m_max_cnt);
    check_eq("max_bin", max_bin, m_max_bin);
    check_eq("ovf", ovf_o, m_ovf);
    check_eq("in_ready", bus.in_ready, !last);
    check_eq("busy", busy_o, last);
  endtask

  // mode 0: out_ready always 1; 1: random with junk hits offered; 2: ready 1-of-3 cycles
  task automatic run_drain(input int unsigned thr, input int mode, input bit check_lat);
    int unsigned   exp_bin[$];
    int unsigned   exp_cnt[$];
    bit            stalled, got_done, rdy;
    logic [RW-2:0] hb;
    logic [CW-1:0] hc;
    int            cyc;
    for (int i = 0; i < RBINS; i++) begin
      if (m_bins[i] >= thr) begin
        exp_bin.push_back(i);
        exp_cnt.push_back(m_bins[i]);
      end
    end
    stalled  = 0;
    got_done = 0;
    cyc      = 0;
    while (!got_done && cyc < 2000) begin
      if (stalled) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_bin", bus.out_bin, hb);
        check_eq("hold_count", bus.out_count, hc);
      end
      if (done_o) begin
        got_done     = 1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_eq("done_out_valid", bus.out_valid, 0);
        check_eq("beats_left", exp_bin.size(), 0);
        if (check_lat) check_eq("done_latency", cyc, RBINS);
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (cyc % 3 == 0);
        endcase
        bus.out_ready = rdy;
        thr_i         = CW'($urandom);
        if (mode == 1) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_data  = RW'($urandom);
          bus.in_last  = 1'($urandom_range(0, 1));
        end
        stalled = 0;
        if (bus.out_valid) begin
          check_eq("beat_expected", exp_bin.size() != 0, 1);
          if (rdy && exp_bin.size() != 0) begin
            check_eq("beat_bin", bus.out_bin, exp_bin.pop_front());
            check_eq("beat_count", bus.out_count, exp_cnt.pop_front());
          end else if (!rdy) begin
            stalled = 1;
            hb      = bus.out_bin;
            hc      = bus.out_count;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("done_seen", got_done, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("clear_busy", busy_o, 1);
    check_eq("clear_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    m_clear();
    check_eq("post_in_ready", bus.in_ready, 1);
    check_eq("post_busy", busy_o, 0);
    check_eq("post_max_count", max_count, 0);
    check_eq("post_max_bin", max_bin, 0);
    check_eq("post_ovf", ovf_o, 0);
  endtask

  initial begin
    bit          v;
    int unsigned pat, n, span, thr, data;
    rst_n         = 1'b0;
    clear_i       = 1'b0;
    thr_i         = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    m_clear();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_max_bin", max_bin, 0);
    check_eq("rst_max_count", max_count, 0);
    check_eq("rst_max_vld", max_vld, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_bin", bus.out_bin, 0);
    check_eq("rst_out_count", bus.out_count, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_ovf", ovf_o, 0);
    rst_n = 1'b1;
    repeat (10) idle_cycle();

    // Fill + max: pulses expected on hits 1, 2 and 5.
    pat = 0;
    send_hit(5, 0, 0, v); pat |= v << 0;
    send_hit(5, 0, 0, v); pat |= v << 1;
    send_hit(9, 0, 0, v); pat |= v << 2;
    send_hit(9, 0, 0, v); pat |= v << 3;
    send_hit(9, 1, 2, v); pat |= v << 4;
    check_eq("fill_max_pattern", pat, 5'b10011);
    check_eq("fill_final_bin", max_bin, 9);
    check_eq("fill_final_count", max_count, 3);
    run_drain(2, 0, 0);

    // Saturation with invalid hits interleaved.
    for (int i = 0; i < 20; i++) begin
      send_hit(3, 0, 0, v);
      if (i == 7) send_hit('h85, 0, 0, v);
    end
    send_hit('hff, 1, 15, v);
    check_eq("sat_ovf", ovf_o, 1);
    check_eq("sat_max_count", max_count, 15);
    run_drain(15, 0, 0);

    // Backpressure, 1-of-3 ready.
    send_hit(0, 0, 0, v);
    send_hit(1, 0, 0, v);
    send_hit(127, 1, 1, v);
    run_drain(1, 2, 0);

    // Empty drain latency.
    send_hit('h80, 1, 1, v);
    run_drain(1, 0, 1);

    // Mid-drain clear, then a clear that collides with a hit.
    send_hit(2, 0, 0, v);
    send_hit(4, 1, 1, v);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_clear_valid", bus.out_valid, 1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    m_clear();
    check_eq("clr_out_valid", bus.out_valid, 0);
    check_eq("clr_in_ready", bus.in_ready, 1);
    check_eq("clr_busy", busy_o, 0);
    check_eq("clr_max_count", max_count, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = RW'(9);
    clear_i       = 1'b1;
    @(posedge clk); #1;
    clear_i      = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("clr_hit_max_vld", max_vld, 0);
    check_eq("clr_hit_max_count", max_count, 0);
    send_hit(7, 1, 1, v);
    run_drain(1, 0, 0);

    // Randomised events.
    for (int e = 0; e < 10; e++) begin
      n    = $urandom_range(1, 40);
      span = $urandom_range(1, 8);
      thr  = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0:       data = 'h80 | $urandom_range(0, 127);
          1:       data = $urandom_range(0, 127);
          default: data = $urandom_range(0, span - 1);
        endcase
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_hit(data, k == n - 1, thr, v);
      end
      run_drain(thr, $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
